// File: rtl/path_scan_ctrl.sv
// path_scan_ctrl: sequential sliding-move path checker.
// Walks every square strictly between the source and target squares, one
// square per clock, using a board snapshot taken when start is accepted.
// The done pulse carries allowPath, aligned and blockSquare. These results
// are held until the next accepted start.
// Optional build macro PATH_TARGET_CHECK_EN adds a TARGET state. That state
// rejects a clear path that would end on a piece of the mover's own colour.
//
// Handshake: start is a single-cycle request. It is sampled only while the
// controller is idle. busy stays high from the cycle after acceptance through
// the done cycle. done is high for exactly one cycle, and the result outputs
// are valid during that cycle.
module path_scan_ctrl #(
  parameter int         MAX_STEPS  = 7,
  parameter logic [2:0] EMPTY_CODE = 3'b000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [5:0]   currentPosition,
  input  logic [5:0]   targetPosition,
  input  logic [255:0] boardInput,
  output logic         busy,
  output logic         done,
  output logic         allowPath,
  output logic         aligned,
  output logic [5:0]   blockSquare
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_TARGET = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]   state;
  logic [255:0] board_q;
  logic [5:0]   cur_q;
  logic [5:0]   tgt_q;
  logic [5:0]   scan_pos;
  logic [5:0]   step_q;
  logic [2:0]   n_q;
  logic [3:0]   iter_q;

  logic signed [3:0] d_row;
  logic signed [3:0] d_col;
  logic [2:0]   a_row;
  logic [2:0]   a_col;
  logic [2:0]   span;
  logic         same_sq;
  logic         line;
  logic [5:0]   step_c;
  logic [5:0]   row_part;
  logic [5:0]   col_part;
  logic         scan_empty;

  // Geometry of the latched move: deltas, alignment and the per-step index offset
  always_comb begin
    d_row    = $signed({1'b0, tgt_q[5:3]}) - $signed({1'b0, cur_q[5:3]});
    d_col    = $signed({1'b0, tgt_q[2:0]}) - $signed({1'b0, cur_q[2:0]});
    a_row    = d_row[3] ? 3'(-d_row) : d_row[2:0];
    a_col    = d_col[3] ? 3'(-d_col) : d_col[2:0];
    span     = (a_row > a_col) ? a_row : a_col;
    same_sq  = (d_row == 4'sd0) && (d_col == 4'sd0);
    line     = ((d_row == 4'sd0) || (d_col == 4'sd0) || (a_row == a_col)) && !same_sq;
    // Negative steps are expressed modulo 64: -8 is 56 and -1 is 63
    row_part = (d_row == 4'sd0) ? 6'd0 : (d_row[3] ? 6'd56 : 6'd8);
    col_part = (d_col == 4'sd0) ? 6'd0 : (d_col[3] ? 6'd63 : 6'd1);
    step_c   = row_part + col_part;
    // Only the piece-type bits decide emptiness; the colour bit is ignored
    scan_empty = (board_q[{scan_pos, 2'b00} +: 3] == EMPTY_CODE);
  end

`ifdef PATH_TARGET_CHECK_EN
  logic [3:0] tgt_piece;
  logic       src_colour;

  // Target square contents and mover colour for the same-colour capture check
  always_comb begin
    tgt_piece  = board_q[{tgt_q, 2'b00} +: 4];
    src_colour = board_q[{cur_q, 2'b11}];
  end
`endif

  // Control FSM and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      board_q     <= '0;
      cur_q       <= '0;
      tgt_q       <= '0;
      scan_pos    <= '0;
      step_q      <= '0;
      n_q         <= '0;
      iter_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      allowPath   <= 1'b0;
      aligned     <= 1'b0;
      blockSquare <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            board_q     <= boardInput;
            cur_q       <= currentPosition;
            tgt_q       <= targetPosition;
            busy        <= 1'b1;
            allowPath   <= 1'b0;
            aligned     <= 1'b0;
            blockSquare <= '0;
            state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          aligned <= line;
          if (same_sq) begin
            allowPath <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (!line) begin
            allowPath <= 1'b1;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            scan_pos <= cur_q + step_c;
            step_q   <= step_c;
            n_q      <= span - 3'd1;
            iter_q   <= '0;
            if (span == 3'd1) begin
`ifdef PATH_TARGET_CHECK_EN
              state     <= S_TARGET;
`else
              allowPath <= 1'b1;
              done      <= 1'b1;
              state     <= S_DONE;
`endif
            end else begin
              state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (int'(iter_q) > MAX_STEPS) begin
            allowPath <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (!scan_empty) begin
            blockSquare <= scan_pos;
            allowPath   <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end else begin
            n_q      <= n_q - 3'd1;
            scan_pos <= scan_pos + step_q;
            iter_q   <= iter_q + 4'd1;
            if (n_q == 3'd1) begin
`ifdef PATH_TARGET_CHECK_EN
              state     <= S_TARGET;
`else
              allowPath <= 1'b1;
              done      <= 1'b1;
              state     <= S_DONE;
`endif
            end
          end
        end
`ifdef PATH_TARGET_CHECK_EN
        S_TARGET: begin
          if ((tgt_piece[2:0] != EMPTY_CODE) && (tgt_piece[3] == src_colour)) begin
            allowPath   <= 1'b0;
            blockSquare <= tgt_q;
          end else begin
            allowPath <= 1'b1;
          end
          done  <= 1'b1;
          state <= S_DONE;
        end
`endif
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_scan_ctrl.sv
// Bench for path_scan_ctrl. The driver issues directed moves and queues the
// hand-computed result and done cycle. The monitor pops one entry per done
// pulse and compares it against the DUT outputs.
module tb_path_scan_ctrl;

`ifdef PATH_TARGET_CHECK_EN
  localparam int TX = 1;
`else
  localparam int TX = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [5:0]   cur;
  logic [5:0]   tgt;
  logic [255:0] board;
  logic         busy, done, allow_path, aligned_o;
  logic [5:0]   block_sq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [39:0] exp_q[$];
  logic [39:0] e;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  path_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .currentPosition(cur), .targetPosition(tgt), .boardInput(board),
    .busy(busy), .done(done), .allowPath(allow_path),
    .aligned(aligned_o), .blockSquare(block_sq)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [255:0] put(input logic [255:0] b, input int s, input logic [3:0] p);
    logic [255:0] r;
    r = b;
    r[4*s +: 4] = p;
    return r;
  endfunction

  // scoreboard monitor: every done pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        check("allowPath", int'(allow_path), int'(e[39]));
        check("aligned", int'(aligned_o), int'(e[38]));
        check("blockSquare", int'(block_sq), int'(e[37:32]));
        check("done_cycle", cyc, int'(e[31:0]));
        check("busy_at_done", int'(busy), 1);
      end
    end
  end

  // driver: pulse start for one cycle, optionally queue the expected result
  task automatic issue(input int c, input int t, input bit ex_allow, input bit ex_al,
                       input int ex_blk, input int lat, input bit push);
    @(negedge clk);
    cur = 6'(c);
    tgt = 6'(t);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) exp_q.push_back({ex_allow, ex_al, 6'(ex_blk), 32'(cyc + lat - 1)});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input int c, input int t, input bit ex_allow, input bit ex_al,
                     input int ex_blk, input int lat);
    issue(c, t, ex_allow, ex_al, ex_blk, lat, 1'b1);
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cur = '0;
    tgt = '0;
    board = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_allow", int'(allow_path), 0);
    check("rst_aligned", int'(aligned_o), 0);
    check("rst_block", int'(block_sq), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // file scan on an empty board: squares 8..48
    run(0, 56, 1, 1, 0, 8 + TX);
    // blocker on the file
    board = put('0, 24, 4'b0101);
    run(0, 56, 0, 1, 24, 5);
    // diagonal with an empty square carrying a set colour bit
    board = put('0, 27, 4'b1000);
    run(0, 63, 1, 1, 0, 8 + TX);
    board = put('0, 27, 4'b1110);
    run(0, 63, 0, 1, 27, 5);
    // rank scan in the negative direction: 62, 61, then blocked at 60
    board = put('0, 60, 4'b0011);
    run(63, 56, 0, 1, 60, 5);
    // knight geometry, edge-crossing pair, same square, adjacent diagonal
    board = '0;
    run(1, 18, 1, 0, 0, 2);
    run(7, 8, 1, 0, 0, 2);
    run(10, 10, 0, 0, 0, 2);
    run(9, 18, 1, 1, 0, 2 + TX);

    // a second start and a board change mid-scan are both ignored
    board = '0;
    issue(0, 56, 1, 1, 0, 8 + TX, 1'b1);
    repeat (2) @(negedge clk);
    board = put('0, 32, 4'b0100);
    cur = 6'd1;
    tgt = 6'd18;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);

    // reset mid-scan aborts at once with no done pulse
    board = '0;
    issue(0, 56, 1, 1, 0, 8, 1'b0);
    repeat (3) @(negedge clk);
    check("busy_mid_scan", int'(busy), 1);
    check("aligned_mid_scan", int'(aligned_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_allow", int'(allow_path), 0);
    check("abort_aligned", int'(aligned_o), 0);
    check("abort_block", int'(block_sq), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

`ifdef PATH_TARGET_CHECK_EN
    // same-colour capture on an adjacent square
    board = put(put('0, 0, 4'b0101), 8, 4'b0110);
    run(0, 8, 0, 1, 8, 3);
    // opposite colour may be captured
    board = put(put('0, 0, 4'b0101), 8, 4'b1110);
    run(0, 8, 1, 1, 0, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
